io_bus_bank: RTL and testbench

Parametrised bidirectional pad bank that sits between the iCE40 tristate pins and the core logic (system bus, SRAM or peripheral data lines). Replaces per-pin primitive wiring with a WIDTH-bit bank: registered output data and output enable, a multi-stage input synchroniser, and a direction-turnaround state machine. The state machine guarantees idle cycles with pins released before the bank drives, and flushes the synchroniser before read data is declared valid.

---
 rtl/io_bus_bank.sv | 116 +++++++++++
 tb/tb_io_bus_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_bank.sv
// Bidirectional pad bank: registered drive path, input synchroniser and a
// turnaround FSM that keeps the pins released around every direction change.
module io_bus_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk25,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] pad,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             tx_active
);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES);
  localparam logic [3:0] SYNC_LOAD = 4'(SYNC_STAGES);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] out_reg;
  logic             oe_reg;
  logic             rd_valid_reg;
  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_ack     = 1'b0;
    case (state_reg)
      ST_RX: begin
        if (wr_req) begin
          if (TURN_CYCLES > 0) begin
            state_next = ST_TURN_TX;
            cnt_next   = TURN_LOAD;
          end else begin
            state_next = ST_TX;
          end
        end
      end
      ST_TURN_TX: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = ST_TX;
      end
      ST_TX: begin
        wr_ack = wr_req & ~rst;
        if (!wr_req) begin
          state_next = ST_TURN_RX;
          cnt_next   = SYNC_LOAD;
        end
      end
      ST_TURN_RX: begin
        // wr_req is deliberately ignored here; RX picks it up once flushed
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = ST_RX;
      end
      default: begin
        state_next = ST_TURN_RX;
        cnt_next   = SYNC_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_reg    <= ST_TURN_RX;
      cnt_reg      <= SYNC_LOAD;
      out_reg      <= '0;
      oe_reg       <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rd_valid_reg <= (state_next == ST_RX);
      if (wr_ack) begin
        out_reg <= wr_data;
        oe_reg  <= 1'b1;
      end else begin
        oe_reg  <= 1'b0;
      end
    end
  end

  // Synchroniser runs in every state, so while driving it echoes our own data
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : gen_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk25) begin
          if (rst) sync_reg[gi] <= '0;
          else     sync_reg[gi] <= pad;
        end
      end else begin : g_rest
        always_ff @(posedge clk25) begin
          if (rst) sync_reg[gi] <= '0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign pad       = oe_reg ? out_reg : {WIDTH{1'bz}};
  assign rd_data   = sync_reg[SYNC_STAGES-1];
  assign rd_valid  = rd_valid_reg;
  assign tx_active = oe_reg;

endmodule

// File: tb/tb_io_bus_bank.sv
// Bench for io_bus_bank: three parameter sets share one stimulus stream and are
// checked each cycle against a timestamp-based reference model.
module tb_io_bus_bank;
  localparam int N = 3;
  localparam int TC [N] = '{1, 0, 4};
  localparam int SS [N] = '{2, 2, 3};
  localparam int HLEN = 4096;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic       rst, wr_req;
  logic [7:0] wr_data, ext_val;
  logic       ext_en [N];
  wire  [7:0] pad0, pad1, pad2;
  logic       ack_w [N], valid_w [N], txa_w [N];
  logic [7:0] rd_w [N];

  assign pad0 = ext_en[0] ? ext_val : 8'hzz;
  assign pad1 = ext_en[1] ? ext_val : 8'hzz;
  assign pad2 = ext_en[2] ? ext_val : 8'hzz;

  io_bus_bank #(.WIDTH(8), .SYNC_STAGES(2), .TURN_CYCLES(1)) u_dut0 (
    .clk25(clk25), .rst(rst), .pad(pad0), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(ack_w[0]), .rd_data(rd_w[0]), .rd_valid(valid_w[0]), .tx_active(txa_w[0]));
  io_bus_bank #(.WIDTH(8), .SYNC_STAGES(2), .TURN_CYCLES(0)) u_dut1 (
    .clk25(clk25), .rst(rst), .pad(pad1), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(ack_w[1]), .rd_data(rd_w[1]), .rd_valid(valid_w[1]), .tx_active(txa_w[1]));
  io_bus_bank #(.WIDTH(8), .SYNC_STAGES(3), .TURN_CYCLES(4)) u_dut2 (
    .clk25(clk25), .rst(rst), .pad(pad2), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(ack_w[2]), .rd_data(rd_w[2]), .rd_valid(valid_w[2]), .tx_active(txa_w[2]));

  // Reference model: bank mode derived from when TX starts / RX resumes
  int         tx_start [N];
  int         rx_start [N];
  logic       m_oe [N];
  logic [7:0] m_out [N];
  logic [7:0] hist [N][HLEN];
  int         last_rst;
  int         t;
  bit         known;

  logic       s_ack [N], s_valid [N], s_txa [N];
  logic [7:0] s_rd [N], s_pad [N];

  int total, bad;

  typedef struct {
    logic       r;
    logic       q;
    logic [7:0] d;
    logic [7:0] e;
    logic       c_st;
    logic       x_ack;
    logic       x_valid;
    logic       x_oe;
    logic [7:0] x_pad;
    logic       c_rd;
    logic [7:0] x_rd;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t v(logic r, logic q, logic [7:0] d, logic [7:0] e, logic c_st,
                             logic x_ack, logic x_valid, logic x_oe, logic [7:0] x_pad,
                             logic c_rd, logic [7:0] x_rd);
    vec_t o;
    o.r = r; o.q = q; o.d = d; o.e = e; o.c_st = c_st; o.x_ack = x_ack;
    o.x_valid = x_valid; o.x_oe = x_oe; o.x_pad = x_pad; o.c_rd = c_rd; o.x_rd = x_rd;
    return o;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0d got=%0h want=%0h", nm, i, t, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic q, input logic [7:0] d, input logic [7:0] e);
    rst = r; wr_req = q; wr_data = d; ext_val = e;
    for (int i = 0; i < N; i++) ext_en[i] = !m_oe[i];
    @(negedge clk25);
    s_pad[0] = pad0; s_pad[1] = pad1; s_pad[2] = pad2;
    for (int i = 0; i < N; i++) begin
      bit         is_tx, is_rx;
      logic [7:0] xpad, xrd;
      s_ack[i] = ack_w[i]; s_valid[i] = valid_w[i]; s_txa[i] = txa_w[i]; s_rd[i] = rd_w[i];
      is_tx = (tx_start[i] >= 0) && (t >= tx_start[i]);
      is_rx = (tx_start[i] < 0) && (t >= rx_start[i]);
      xpad  = m_oe[i] ? m_out[i] : e;
      hist[i][t % HLEN] = xpad;
      xrd = 8'h00;
      if (known && (t - SS[i] > last_rst)) xrd = hist[i][(t - SS[i]) % HLEN];
      if (known) begin
        chk("wr_ack", i, 32'(s_ack[i]), 32'(is_tx && q && !r));
        chk("rd_valid", i, 32'(s_valid[i]), 32'(is_rx));
        chk("tx_active", i, 32'(s_txa[i]), 32'(m_oe[i]));
        chk("rd_data", i, 32'(s_rd[i]), 32'(xrd));
        if (m_oe[i]) chk("pad", i, 32'(s_pad[i]), 32'(m_out[i]));
      end
      if (r) begin
        tx_start[i] = -1;
        rx_start[i] = t + 1 + SS[i];
        m_oe[i]     = 1'b0;
        m_out[i]    = 8'h00;
      end else begin
        m_oe[i] = is_tx && q;
        if (is_tx && q) m_out[i] = d;
        if (is_rx && q) begin
          tx_start[i] = t + 1 + TC[i];
        end else if (is_tx && !q) begin
          tx_start[i] = -1;
          rx_start[i] = t + 1 + SS[i];
        end
      end
    end
    if (r) begin
      last_rst = t;
      known    = 1'b1;
    end
    t++;
    @(posedge clk25);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    int   first_ack [N];
    logic [7:0] rd0 [4];
    logic [7:0] rd2 [4];
    logic q_state;

    total = 0; bad = 0; t = 0; known = 1'b0; last_rst = -1000;
    for (int i = 0; i < N; i++) begin
      tx_start[i] = -1; rx_start[i] = 0; m_oe[i] = 1'b0; m_out[i] = 8'h00; ext_en[i] = 1'b1;
    end
    rst = 1'b1; wr_req = 1'b0; wr_data = 8'h00; ext_val = 8'hA5;

    // Directed vectors for the default-parameter bank (inst 0)
    //             r  q  d      e      st ack val oe pad    crd rd
    vecs.push_back(v(1, 0, 8'h00, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(1, 0, 8'h00, 8'hA5, 1, 0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(1, 0, 8'h00, 8'hA5, 1, 0, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(0, 0, 8'h00, 8'hA5, 1, 0, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(0, 0, 8'h00, 8'hA5, 1, 0, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(0, 0, 8'h00, 8'hA5, 1, 0, 1, 0, 8'h00, 1, 8'hA5));
    vecs.push_back(v(0, 0, 8'h00, 8'hA5, 1, 0, 1, 0, 8'h00, 1, 8'hA5));
    vecs.push_back(v(0, 1, 8'h3C, 8'hA5, 1, 0, 1, 0, 8'h00, 1, 8'hA5));
    vecs.push_back(v(0, 1, 8'h3C, 8'hA5, 1, 0, 0, 0, 8'h00, 1, 8'hA5));
    vecs.push_back(v(0, 1, 8'h3C, 8'hA5, 1, 1, 0, 0, 8'h00, 1, 8'hA5));
    vecs.push_back(v(0, 0, 8'h3C, 8'hA5, 1, 0, 0, 1, 8'h3C, 1, 8'hA5));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'hA5));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h3C));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 1, 0, 8'h00, 1, 8'h5A));
    vecs.push_back(v(0, 1, 8'h01, 8'h5A, 1, 0, 1, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 1, 8'h01, 8'h5A, 1, 0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 1, 8'h01, 8'h5A, 1, 1, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 1, 8'h02, 8'h5A, 1, 1, 0, 1, 8'h01, 0, 8'h00));
    vecs.push_back(v(0, 1, 8'h04, 8'h5A, 1, 1, 0, 1, 8'h02, 1, 8'h5A));
    vecs.push_back(v(0, 1, 8'h08, 8'h5A, 1, 1, 0, 1, 8'h04, 1, 8'h01));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 1, 8'h08, 1, 8'h02));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h04));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h08));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 1, 0, 8'h00, 1, 8'h5A));
    vecs.push_back(v(0, 1, 8'h11, 8'h5A, 1, 0, 1, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 1, 8'h11, 8'h5A, 1, 0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 1, 8'h11, 8'h5A, 1, 1, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(1, 1, 8'h22, 8'h5A, 1, 0, 0, 1, 8'h11, 0, 8'h00));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(0, 1, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(v(0, 1, 8'h33, 8'h5A, 1, 0, 1, 0, 8'h00, 1, 8'h5A));
    vecs.push_back(v(0, 1, 8'h33, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h5A));
    vecs.push_back(v(0, 1, 8'h33, 8'h5A, 1, 1, 0, 0, 8'h00, 1, 8'h5A));
    vecs.push_back(v(0, 0, 8'h33, 8'h5A, 1, 0, 0, 1, 8'h33, 1, 8'h5A));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h5A));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 0, 0, 8'h00, 1, 8'h33));
    vecs.push_back(v(0, 0, 8'h00, 8'h5A, 1, 0, 1, 0, 8'h00, 1, 8'h5A));

    @(posedge clk25);
    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      cyc(vecs[k].r, vecs[k].q, vecs[k].d, vecs[k].e);
      $display("vec %0d: rst=%b req=%b data=%h ack=%b valid=%b oe=%b pad=%h rd=%h", k,
               vecs[k].r, vecs[k].q, vecs[k].d, s_ack[0], s_valid[0], s_txa[0], s_pad[0], s_rd[0]);
      chk("vec_ack", 0, 32'(s_ack[0]), 32'(vecs[k].x_ack));
      if (vecs[k].c_st) begin
        chk("vec_valid", 0, 32'(s_valid[0]), 32'(vecs[k].x_valid));
        chk("vec_oe", 0, 32'(s_txa[0]), 32'(vecs[k].x_oe));
        if (vecs[k].x_oe) chk("vec_pad", 0, 32'(s_pad[0]), 32'(vecs[k].x_pad));
      end
      if (vecs[k].c_rd) chk("vec_rd", 0, 32'(s_rd[0]), 32'(vecs[k].x_rd));
    end

    // Turnaround latency for TURN_CYCLES = 1, 0, 4
    cyc(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (5) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < N; i++) first_ack[i] = -1;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 8'(8'h40 + k), 8'h00);
      $display("turn k=%0d ack=%b%b%b oe=%b%b%b", k, s_ack[0], s_ack[1], s_ack[2],
               s_txa[0], s_txa[1], s_txa[2]);
      for (int i = 0; i < N; i++) if (s_ack[i] && first_ack[i] < 0) first_ack[i] = k;
      if (k <= 5) chk("turn_tx_released", 2, 32'(s_txa[2]), 32'd0);
    end
    chk("first_ack_tc1", 0, 32'(first_ack[0]), 32'd2);
    chk("first_ack_tc0", 1, 32'(first_ack[1]), 32'd1);
    chk("first_ack_tc4", 2, 32'(first_ack[2]), 32'd5);

    // Read path latency for SYNC_STAGES = 2 and 3
    repeat (6) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 8'hFF);
      $display("read k=%0d rd0=%h rd2=%h valid=%b%b", k, s_rd[0], s_rd[2], s_valid[0], s_valid[2]);
      rd0[k] = s_rd[0];
      rd2[k] = s_rd[2];
      chk("read_valid", 0, 32'(s_valid[0]), 32'd1);
      chk("read_valid", 2, 32'(s_valid[2]), 32'd1);
    end
    chk("read_ss2_before", 0, 32'(rd0[1]), 32'h00);
    chk("read_ss2_at", 0, 32'(rd0[2]), 32'hFF);
    chk("read_ss3_before", 2, 32'(rd2[2]), 32'h00);
    chk("read_ss3_at", 2, 32'(rd2[3]), 32'hFF);

    // Randomised traffic with occasional resets
    q_state = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      logic r;
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) q_state = ~q_state;
      r = ($urandom_range(0, 79) == 0);
      d = 8'($urandom);
      cyc(r, q_state, d, 8'($urandom));
      if (s_ack[0]) $display("word t=%0d data=%h", t - 1, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
